imem_responder: RTL
===================

# imem_responder

Instruction-memory responder for the single-cycle ARM fetch stage. It answers PC-addressed fetch reads with one-cycle registered latency and holds the fetch side stalled until memory is loaded. It also owns a byte-serial boot-load port that assembles little-endian words and writes them into the backing store. It sits between the fetch stage (PC in, Instr out) and the board-level program loader.

## Interface
- DEPTH, 256: memory size in 32-bit words (power of two, ≥ 4)
- NOP, 32'hE1A00000: word returned on a faulting fetch (MOV r0,r0)

- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- PC  in  32  fetch byte address
- Instr  out  32  registered fetch data
- InstrValid  out  1  Instr holds a valid response to the PC sampled last cycle
- Stall  out  1  fetch must hold PC; high whenever not in RUN
- Fault  out  1  registered; last sampled PC misaligned or out of range
- LdStart  in  1  begin a load; sampled in IDLE or RUN
- LdLen  in  16  words to load; sampled with LdStart
- LdByte  in  8  load data byte
- LdValid  in  1  LdByte valid
- LdReady  out  1  responder accepts a byte this cycle
- LdDone  out  1  one-cycle pulse when a load completes

## Operation
- States: IDLE (after reset), LOAD, RUN.
- Reset: state IDLE, Instr=0, InstrValid=0, Stall=1, Fault=0, LdReady=0, LdDone=0, word pointer=0, byte lane=0. Memory contents are not cleared.
- IDLE: LdStart=1 moves to LOAD. Everything else is ignored.
- LdStart handling:
  - Latch len = min(LdLen, DEPTH), ptr=0, lane=0.
  - If len=0, go directly to RUN and pulse LdDone.
- LOAD:
  - LdReady=1. A byte is accepted when LdValid && LdReady.
  - The byte goes into lane `lane` of the assembly word: lane 0 is bits [7:0], lane 3 is bits [31:24].
  - On acceptance of the lane-3 byte, write the assembled word to mem[ptr], increment ptr and set lane=0.
  - If the new ptr equals len, the next state is RUN and LdDone pulses in that cycle.
  - LdStart is ignored while in LOAD.
- RUN:
  - Stall=0, LdReady=0.
  - Each cycle, sample PC. Fault is set if PC[1:0]≠0 or PC[31:2] ≥ DEPTH.
  - Next cycle: Instr = Fault ? NOP : mem[PC[log2(DEPTH)+1:2]], and InstrValid=1.
  - LdStart in RUN moves to LOAD (reload). InstrValid and Fault go to 0 on the following edge, and Stall=1.
- Outside RUN, Instr holds its last value, InstrValid=0 and Fault=0.
- A partial word left when leaving LOAD is not possible, because completion only occurs on a lane-3 write.
- Reset in LOAD returns to IDLE. Already-written words are retained and lane/ptr are discarded.

## Timing
- Fetch read latency: 1 cycle, PC at edge t → Instr/InstrValid/Fault valid after edge t+1.
- RUN is entered at edge e. The first InstrValid=1 follows edge e+1, using the PC sampled at edge e+1.
- Load throughput: 1 byte per cycle. A word write occurs in the same edge as its 4th byte.
- The last write and the LOAD→RUN transition share an edge. A fetch sampled after that edge sees the new data (no read-during-write hazard).
- LdDone is high for exactly the cycle after the completing edge, alongside the first cycle of Stall=0.
- LdStart and LdValid in the same IDLE/RUN cycle: the byte is not accepted (LdReady=0). The loader must re-present it.
- RST has priority over LdStart and all load activity.

## Test plan
- Reset, then LdStart with LdLen=2 and bytes 78 56 34 12 EF BE AD DE, one per cycle:
  - LdDone pulses once after the 8th byte, then Stall=0.
  - PC=0 → Instr=32'h12345678 one cycle later.
  - PC=4 → Instr=32'hDEADBEEF.
- Back-to-back PCs 0,4,0 in RUN: Instr follows one cycle behind each PC with no bubbles, InstrValid=1.
- PC=2, then PC=DEPTH*4: Fault=1 and Instr=32'hE1A00000 in the cycle after each. A following PC=0 clears Fault.
- LdValid gaps (byte every 3rd cycle) with LdLen=1: the word is written correctly and LdReady stays 1 throughout LOAD.
- LdStart with LdLen=0: goes straight to RUN with a LdDone pulse. LdLen=16'hFFFF with DEPTH=256 completes after 1024 bytes.
- RST asserted after 5 bytes of a 2-word load:
  - Result is IDLE with Stall=1, LdReady=0.
  - A new load of 1 word overwrites mem[0]. mem[1] is unchanged from the prior content.

Source files
------------

// File: rtl/imem_responder.sv
// imem_responder: instruction-memory responder for the single-cycle ARM fetch
// stage. Serves PC-addressed fetches with one-cycle registered latency, keeps
// fetch stalled until memory is loaded, and assembles little-endian words from
// a byte-serial boot-load port into the backing store.
module imem_responder #(
    parameter int unsigned DEPTH = 256,
    parameter logic [31:0] NOP   = 32'hE1A00000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] PC,
    output logic [31:0] Instr,
    output logic        InstrValid,
    output logic        Stall,
    output logic        Fault,
    input  logic        LdStart,
    input  logic [15:0] LdLen,
    input  logic [7:0]  LdByte,
    input  logic        LdValid,
    output logic        LdReady,
    output logic        LdDone
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN
    } state_e;

    logic [31:0]   mem [DEPTH];

    state_e        state_q, state_d;
    logic [LW-1:0] ptr_q, ptr_d;
    logic [LW-1:0] len_q, len_d;
    logic [1:0]    lane_q, lane_d;
    logic [23:0]   asm_q, asm_d;
    logic [31:0]   instr_q, instr_d;
    logic          ivalid_q, ivalid_d;
    logic          fault_q, fault_d;
    logic          stall_q, stall_d;
    logic          ldready_q, ldready_d;
    logic          lddone_q, lddone_d;
    logic          mem_we;

    logic [31:0]   ld_len_ext;
    logic [LW-1:0] ld_len_clip;
    logic          fetch_fault;
    logic [AW-1:0] fetch_idx;
    logic [LW-1:0] ptr_inc;

    assign ld_len_ext  = 32'(LdLen);
    assign ld_len_clip = (ld_len_ext >= DEPTH) ? LW'(DEPTH) : LW'(ld_len_ext);
    assign fetch_fault = (PC[1:0] != 2'b00) || (PC[31:AW+2] != '0);
    assign fetch_idx   = PC[AW+1:2];
    assign ptr_inc     = ptr_q + LW'(1);

    // Next-state logic for the load/run controller and the fetch pipeline register
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        len_d    = len_q;
        lane_d   = lane_q;
        asm_d    = asm_q;
        instr_d  = instr_q;
        ivalid_d = 1'b0;
        fault_d  = 1'b0;
        lddone_d = 1'b0;
        mem_we   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (LdStart) begin
                    len_d  = ld_len_clip;
                    ptr_d  = '0;
                    lane_d = '0;
                    if (ld_len_clip == '0) begin
                        state_d  = S_RUN;
                        lddone_d = 1'b1;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end

            S_LOAD: begin
                if (LdValid && ldready_q) begin
                    unique case (lane_q)
                        2'd0: begin asm_d[7:0]   = LdByte; lane_d = 2'd1; end
                        2'd1: begin asm_d[15:8]  = LdByte; lane_d = 2'd2; end
                        2'd2: begin asm_d[23:16] = LdByte; lane_d = 2'd3; end
                        default: begin
                            mem_we = 1'b1;
                            ptr_d  = ptr_inc;
                            lane_d = 2'd0;
                            if (ptr_inc == len_q) begin
                                state_d  = S_RUN;
                                lddone_d = 1'b1;
                            end
                        end
                    endcase
                end
            end

            S_RUN: begin
                // A zero-length reload stays in RUN, so the fetch still proceeds
                if (LdStart && ld_len_clip != '0) begin
                    len_d   = ld_len_clip;
                    ptr_d   = '0;
                    lane_d  = '0;
                    state_d = S_LOAD;
                end else begin
                    if (LdStart) begin
                        len_d    = ld_len_clip;
                        ptr_d    = '0;
                        lane_d   = '0;
                        lddone_d = 1'b1;
                    end
                    fault_d  = fetch_fault;
                    instr_d  = fetch_fault ? NOP : mem[fetch_idx];
                    ivalid_d = 1'b1;
                end
            end

            default: state_d = S_IDLE;
        endcase

        stall_d   = (state_d != S_RUN);
        ldready_d = (state_d == S_LOAD);
    end

    // Controller and registered outputs; reset takes priority over all load activity
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            len_q     <= '0;
            lane_q    <= '0;
            asm_q     <= '0;
            instr_q   <= '0;
            ivalid_q  <= 1'b0;
            fault_q   <= 1'b0;
            stall_q   <= 1'b1;
            ldready_q <= 1'b0;
            lddone_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            len_q     <= len_d;
            lane_q    <= lane_d;
            asm_q     <= asm_d;
            instr_q   <= instr_d;
            ivalid_q  <= ivalid_d;
            fault_q   <= fault_d;
            stall_q   <= stall_d;
            ldready_q <= ldready_d;
            lddone_q  <= lddone_d;
        end
    end

    // Backing store write; contents survive reset, but reset blocks a pending write
    always_ff @(posedge CLK) begin
        if (mem_we && !RST) begin
            mem[ptr_q[AW-1:0]] <= {LdByte, asm_q};
        end
    end

    assign Instr      = instr_q;
    assign InstrValid = ivalid_q;
    assign Fault      = fault_q;
    assign Stall      = stall_q;
    assign LdReady    = ldready_q;
    assign LdDone     = lddone_q;

endmodule
